// File: rtl/perf_monitor.sv
// perf_monitor: nine event counters (branch, bus and cache activity) gated
// by a start/stop run state, with sticky wrap flags, synchronous clear and
// a one-cycle-latency read port.
module perf_monitor #(
  parameter int CW = 32
) (
  input  logic        clk_core,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        ex_br,
  input  logic        ex_br_miss,
  input  logic        bus_cmd_valid,
  input  logic        bus_cmd_beat,
  input  logic        bus_cmd_read,
  input  logic        ic_req,
  input  logic        ic_hit,
  input  logic        dc_req,
  input  logic        dc_hit,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        rd_req,
  input  logic [3:0]  rd_addr,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        counting
);

  // state | meaning
  // IDLE  | counters hold their values
  // RUN   | counters advance on qualified events
  typedef enum logic {IDLE, RUN} state_t;

  localparam int NCNT = 9;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt [NCNT];
  logic [NCNT-1:0]   ovf;
  logic [NCNT-1:0]   inc;
  logic              ic_req_q, dc_req_q;
  logic [31:0]       rd_mux;

  // run-state register
  always_ff @(posedge clk_core or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next state and run indication; start together with stop is ignored
  always_comb begin
    state_nxt = state;
    counting  = 1'b0;
    case (state)
      IDLE: if (start && !stop) state_nxt = RUN;
      RUN: begin
        counting = 1'b1;
        if (stop && !start) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // cache lookups resolve one cycle after the request, so hold the request
  // flag; it is captured in any state and only qualified when the hit arrives
  always_ff @(posedge clk_core or posedge reset) begin
    if (reset) begin
      ic_req_q <= 1'b0;
      dc_req_q <= 1'b0;
    end else if (clear) begin
      ic_req_q <= 1'b0;
      dc_req_q <= 1'b0;
    end else begin
      ic_req_q <= ic_req;
      dc_req_q <= dc_req;
    end
  end

  // per-counter event strobes, indexed by read address
  always_comb begin
    inc    = '0;
    inc[0] = ex_valid & ex_br;
    inc[1] = ex_valid & ex_br_miss;
    inc[2] = bus_cmd_valid;
    inc[3] = bus_cmd_beat & bus_cmd_read;
    inc[4] = bus_cmd_beat & ~bus_cmd_read;
    inc[5] = ic_req_q & ic_hit;
    inc[6] = ic_req_q & ~ic_hit;
    inc[7] = dc_req_q & dc_hit;
    inc[8] = dc_req_q & ~dc_hit;
  end

  // counters and sticky wrap flags; clear beats any same-cycle increment
  always_ff @(posedge clk_core or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCNT; i++) cnt[i] <= '0;
      ovf <= '0;
    end else if (clear) begin
      for (int i = 0; i < NCNT; i++) cnt[i] <= '0;
      ovf <= '0;
    end else if (counting) begin
      for (int i = 0; i < NCNT; i++) begin
        if (inc[i]) begin
          cnt[i] <= cnt[i] + CW'(1);
          if (&cnt[i]) ovf[i] <= 1'b1;
        end
      end
    end
  end

  // read selection from the current (pre-increment, pre-clear) values
  always_comb begin
    rd_mux = '0;
    if (rd_addr < 4'd9)       rd_mux[CW-1:0] = cnt[rd_addr];
    else if (rd_addr == 4'd9) rd_mux[8:0]    = ovf;
  end

  // registered read response; data forced to zero when no response
  always_ff @(posedge clk_core or posedge reset) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      rd_data  <= rd_req ? rd_mux : 32'd0;
    end
  end

endmodule

// File: tb/tb_perf_monitor.sv
// Bench for perf_monitor: directed scenarios plus randomized traffic
// against an event-level reference model.
module tb_perf_monitor;
  localparam int CW = 8;

  logic        clk_core = 1'b0;
  logic        reset = 1'b1;
  logic        ex_valid = 0, ex_br = 0, ex_br_miss = 0;
  logic        bus_cmd_valid = 0, bus_cmd_beat = 0, bus_cmd_read = 0;
  logic        ic_req = 0, ic_hit = 0, dc_req = 0, dc_hit = 0;
  logic        start = 0, stop = 0, clear = 0;
  logic        rd_req = 0;
  logic [3:0]  rd_addr = 0;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        counting;

  int checks = 0;
  int failures = 0;

  perf_monitor #(.CW(CW)) dut (
    .clk_core(clk_core), .reset(reset),
    .ex_valid(ex_valid), .ex_br(ex_br), .ex_br_miss(ex_br_miss),
    .bus_cmd_valid(bus_cmd_valid), .bus_cmd_beat(bus_cmd_beat), .bus_cmd_read(bus_cmd_read),
    .ic_req(ic_req), .ic_hit(ic_hit), .dc_req(dc_req), .dc_hit(dc_hit),
    .start(start), .stop(stop), .clear(clear),
    .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data), .counting(counting)
  );

  always #5 clk_core = ~clk_core;

  // reference model: event tallies, wrap flags, pending lookups, run flag
  int unsigned m_cnt [9];
  logic [8:0]  m_ovf;
  bit          m_run, m_icp, m_dcp;
  logic        exp_rv, nxt_rv;
  logic [31:0] exp_rd, nxt_rd;

  function automatic logic [31:0] m_read(input logic [3:0] a);
    if (a < 9)  return 32'(m_cnt[a]);
    if (a == 9) return {23'd0, m_ovf};
    return 32'd0;
  endfunction

  function automatic void bump(input int i);
    m_cnt[i] = (m_cnt[i] + 1) % (1 << CW);
    if (m_cnt[i] == 0) m_ovf[i] = 1'b1;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 9; i++) m_cnt[i] = 0;
    m_ovf = '0; m_run = 0; m_icp = 0; m_dcp = 0;
    exp_rv = 0; exp_rd = 0;
  endfunction

  function automatic void model_step();
    nxt_rv = rd_req;
    nxt_rd = rd_req ? m_read(rd_addr) : 32'd0;
    if (clear) begin
      for (int i = 0; i < 9; i++) m_cnt[i] = 0;
      m_ovf = '0; m_icp = 0; m_dcp = 0;
    end else begin
      if (m_run) begin
        if (ex_valid && ex_br)            bump(0);
        if (ex_valid && ex_br_miss)       bump(1);
        if (bus_cmd_valid)                bump(2);
        if (bus_cmd_beat && bus_cmd_read) bump(3);
        if (bus_cmd_beat && !bus_cmd_read) bump(4);
        if (m_icp) bump(ic_hit ? 5 : 6);
        if (m_dcp) bump(dc_hit ? 7 : 8);
      end
      m_icp = ic_req; m_dcp = dc_req;
    end
    if (start && !stop) m_run = 1;
    else if (stop && !start) m_run = 0;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk_core);
    #1;
    exp_rv = nxt_rv;
    exp_rd = nxt_rd;
  endtask

  task automatic idle();
    ex_valid = 0; ex_br = 0; ex_br_miss = 0;
    bus_cmd_valid = 0; bus_cmd_beat = 0; bus_cmd_read = 0;
    ic_req = 0; ic_hit = 0; dc_req = 0; dc_hit = 0;
    start = 0; stop = 0; clear = 0; rd_req = 0; rd_addr = 0;
  endtask

  task automatic pulse_clear();  clear = 1; tick(); clear = 0; endtask
  task automatic pulse_start();  start = 1; tick(); start = 0; endtask
  task automatic pulse_stop();   stop = 1;  tick(); stop = 0;  endtask
  task automatic issue_read(input logic [3:0] a);
    rd_req = 1; rd_addr = a; tick(); rd_req = 0; rd_addr = 0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    repeat (2) @(posedge clk_core);
    #1;
    checks++;
    if (counting !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_outputs: counting=%b rd_valid=%b rd_data=%h, want 0/0/0", counting, rd_valid, rd_data);
    end
    reset = 0;
    model_reset();
    for (int a = 0; a < 10; a++) begin
      issue_read(4'(a));
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 32'd0) begin
        failures++;
        $display("FAIL reset_read[%0d]: rd_valid=%b rd_data=%h, want 1/0", a, rd_valid, rd_data);
      end
    end
  endtask

  task automatic test_branches();
    pulse_clear();
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      ex_valid = 1; ex_br = 1; ex_br_miss = (i < 2);
      tick();
    end
    idle();
    ex_br_miss = 1;
    tick();
    idle();
    issue_read(0);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 32'd5) begin
      failures++;
      $display("FAIL branches: rd_valid=%b rd_data=%0d, want 1/5", rd_valid, rd_data);
    end
    issue_read(1);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 32'd2) begin
      failures++;
      $display("FAIL br_miss: rd_valid=%b rd_data=%0d, want 1/2", rd_valid, rd_data);
    end
    pulse_stop();
    checks++;
    if (counting !== 1'b0) begin
      failures++;
      $display("FAIL stop_state: counting=%b, want 0", counting);
    end
  endtask

  task automatic test_cache_stop();
    pulse_clear();
    pulse_start();
    ic_req = 1; tick();
    ic_req = 0; ic_hit = 0; stop = 1; tick();
    stop = 0; tick();
    issue_read(6);
    checks++;
    if (rd_data !== 32'd1) begin
      failures++;
      $display("FAIL ic_miss_stop_late: rd_data=%0d, want 1", rd_data);
    end
    issue_read(5);
    checks++;
    if (rd_data !== 32'd0) begin
      failures++;
      $display("FAIL ic_hit_stop_late: rd_data=%0d, want 0", rd_data);
    end
    pulse_clear();
    pulse_start();
    ic_req = 1; stop = 1; tick();
    ic_req = 0; stop = 0; ic_hit = 0; tick();
    idle();
    issue_read(6);
    checks++;
    if (rd_data !== 32'd0 || counting !== 1'b0) begin
      failures++;
      $display("FAIL ic_miss_stop_early: rd_data=%0d counting=%b, want 0/0", rd_data, counting);
    end
  endtask

  task automatic test_wrap();
    pulse_clear();
    pulse_start();
    bus_cmd_valid = 1;
    repeat (256) tick();
    bus_cmd_valid = 0;
    pulse_stop();
    issue_read(2);
    checks++;
    if (rd_data !== 32'd0) begin
      failures++;
      $display("FAIL wrap_count: rd_data=%0d, want 0", rd_data);
    end
    issue_read(9);
    checks++;
    if (rd_data !== 32'h004) begin
      failures++;
      $display("FAIL wrap_ovf: rd_data=%h, want 004", rd_data);
    end
  endtask

  task automatic test_clear_read();
    pulse_clear();
    pulse_start();
    ex_valid = 1; ex_br = 1;
    repeat (7) tick();
    clear = 1; rd_req = 1; rd_addr = 0;
    tick();
    idle();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 32'd7) begin
      failures++;
      $display("FAIL clear_read_pre: rd_valid=%b rd_data=%0d, want 1/7", rd_valid, rd_data);
    end
    issue_read(0);
    checks++;
    if (rd_data !== 32'd0) begin
      failures++;
      $display("FAIL clear_read_post: rd_data=%0d, want 0", rd_data);
    end
  endtask

  task automatic test_back_to_back();
    pulse_clear();
    if (!m_run) pulse_start();
    for (int i = 0; i < 3; i++) begin
      ex_valid = 1; ex_br = 1; ex_br_miss = (i == 1);
      tick();
    end
    idle();
    issue_read(12);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 32'd0) begin
      failures++;
      $display("FAIL addr12: rd_valid=%b rd_data=%h, want 1/0", rd_valid, rd_data);
    end
    rd_req = 1; rd_addr = 0; tick();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 32'd3) begin
      failures++;
      $display("FAIL b2b_0: rd_valid=%b rd_data=%0d, want 1/3", rd_valid, rd_data);
    end
    rd_addr = 1; tick();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 32'd1) begin
      failures++;
      $display("FAIL b2b_1: rd_valid=%b rd_data=%0d, want 1/1", rd_valid, rd_data);
    end
    rd_addr = 12; tick();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 32'd0) begin
      failures++;
      $display("FAIL b2b_2: rd_valid=%b rd_data=%0d, want 1/0", rd_valid, rd_data);
    end
    rd_req = 0; rd_addr = 0; tick();
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 32'd0) begin
      failures++;
      $display("FAIL b2b_end: rd_valid=%b rd_data=%h, want 0/0", rd_valid, rd_data);
    end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    pulse_clear();
    for (int c = 0; c < 800; c++) begin
      ex_valid      = ($urandom_range(0, 3) != 0);
      ex_br         = $urandom_range(0, 1);
      ex_br_miss    = ($urandom_range(0, 3) == 0);
      bus_cmd_valid = $urandom_range(0, 1) | ($urandom_range(0, 1));
      bus_cmd_beat  = $urandom_range(0, 1);
      bus_cmd_read  = $urandom_range(0, 1);
      ic_req        = $urandom_range(0, 1);
      ic_hit        = $urandom_range(0, 1);
      dc_req        = $urandom_range(0, 1);
      dc_hit        = $urandom_range(0, 1);
      start         = ($urandom_range(0, 7) == 0);
      stop          = ($urandom_range(0, 15) == 0);
      clear         = ($urandom_range(0, 199) == 0);
      rd_req        = $urandom_range(0, 1);
      rd_addr       = 4'($urandom_range(0, 15));
      tick();
      checks++;
      if (rd_valid !== exp_rv || rd_data !== exp_rd || counting !== m_run) begin
        failures++;
        errs++;
        if (errs <= 10)
          $display("FAIL random[%0d]: rd_valid=%b rd_data=%h counting=%b, want %b/%h/%b",
                   c, rd_valid, rd_data, counting, exp_rv, exp_rd, m_run);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    pulse_clear();
    if (!m_run) pulse_start();
    ex_valid = 1; ex_br = 1; bus_cmd_valid = 1;
    repeat (4) tick();
    idle();
    rd_req = 1; rd_addr = 0;
    tick();
    rd_req = 0;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 32'd4) begin
      failures++;
      $display("FAIL pre_reset_read: rd_valid=%b rd_data=%0d, want 1/4", rd_valid, rd_data);
    end
    #2 reset = 1;
    #1;
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 32'd0 || counting !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: rd_valid=%b rd_data=%h counting=%b, want 0/0/0", rd_valid, rd_data, counting);
    end
    model_reset();
    @(posedge clk_core);
    #1 reset = 0;
    for (int a = 0; a < 10; a++) begin
      issue_read(4'(a));
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 32'd0 || counting !== 1'b0) begin
        failures++;
        $display("FAIL post_reset_read[%0d]: rd_valid=%b rd_data=%h counting=%b, want 1/0/0",
                 a, rd_valid, rd_data, counting);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_branches();
    test_cache_stop();
    test_wrap();
    test_clear_read();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/perf_monitor.md
PERF_MONITOR -- requirements
Module: perf_monitor

Interface
REQ-001 SHALL have parameter CW, default 32, event counter width in bits (legal range 8..32).
REQ-002 SHALL have port clk_core, input, 1, core clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port ex_valid, ex_br, ex_br_miss, inputs, 1 each, execute-stage valid, branch and branch-mispredict flags.
REQ-005 SHALL have port bus_cmd_valid, bus_cmd_beat, bus_cmd_read, inputs, 1 each, main bus busy, accepted beat, beat-is-read.
REQ-006 SHALL have port ic_req, ic_hit, dc_req, dc_hit, inputs, 1 each, cache lookup request and next-cycle hit result.
REQ-007 SHALL have port start, stop, clear, inputs, 1 each, single-cycle control pulses.
REQ-008 SHALL have port rd_req, input, 1, and rd_addr, input, 4, counter read request and index.
REQ-009 SHALL have port rd_valid, output, 1, and rd_data, output, 32, read response.
REQ-010 SHALL have port counting, output, 1, high while in state RUN.

Function
REQ-011 SHALL keep counters 0..8: branches, br_miss, bus_busy, bus_reads, bus_writes, ic_hits, ic_misses, dc_hits, dc_misses, each CW bits.
REQ-012 SHALL implement states IDLE and RUN; IDLE->RUN on start, RUN->IDLE on stop; start and stop together: no transition.
REQ-013 SHALL increment counters only in RUN; in IDLE all counters hold.
REQ-014 SHALL count branches when ex_valid&ex_br, br_miss when ex_valid&ex_br_miss; ex_br_miss without ex_valid not counted.
REQ-015 SHALL count bus_busy each cycle bus_cmd_valid; bus_reads when bus_cmd_beat&bus_cmd_read; bus_writes when bus_cmd_beat&!bus_cmd_read.
REQ-016 SHALL register ic_req/dc_req one cycle; when registered request is high, count hit if ic_hit/dc_hit that cycle, else miss.
REQ-017 SHALL apply the RUN qualification at the sampling cycle of ic_hit/dc_hit, not at the request cycle.
REQ-018 SHALL wrap each counter modulo 2^CW and set that counter's sticky overflow bit on wrap.
REQ-019 SHALL clear all counters, overflow bits and registered cache requests on clear; state unchanged.
REQ-020 SHALL give clear priority over any same-cycle increment (result 0, overflow 0).
REQ-021 SHALL respond to rd_req with rd_valid=1 exactly one cycle later, rd_data sampled at the request cycle (pre-increment value).
REQ-022 SHALL return counter value zero-extended to 32 bits for rd_addr 0..8; overflow bits in rd_data[8:0] for rd_addr 9; zero for rd_addr 10..15.
REQ-023 SHALL hold rd_data at 0 when rd_valid is 0.
REQ-024 SHALL accept back-to-back rd_req every cycle, one response per request, in order.
REQ-025 SHALL allow reads in any state, concurrent with counting and clear; read same cycle as clear returns pre-clear value.

Reset
REQ-026 SHALL on reset assertion immediately force state IDLE, all counters, overflow bits, registered requests to 0.
REQ-027 SHALL drive rd_valid=0, rd_data=0, counting=0 during and after reset until stimulus.
REQ-028 SHALL drop any in-flight read response when reset asserts mid-operation.

Verification
REQ-029 SHALL verify: reset, start, 5 cycles ex_valid&ex_br with ex_br_miss on 2 -> read addr 0 returns 5, addr 1 returns 2.
REQ-030 SHALL verify: RUN, ic_req in cycle n, ic_hit=0 in n+1, stop in n+1 -> ic_misses=1; stop at n -> ic_misses=0.
REQ-031 SHALL verify: CW=8, 256 bus_cmd_valid cycles -> addr 2 returns 0, addr 9 returns 0x004.
REQ-032 SHALL verify: clear coincident with ex_valid&ex_br and rd_req addr 0 (value 7) -> rd_data=7 next cycle, subsequent read returns 0.
REQ-033 SHALL verify: rd_req addr 12 -> rd_valid=1, rd_data=0; rd_req on 3 consecutive cycles -> 3 consecutive rd_valid pulses.
REQ-034 SHALL verify: reset asserted mid-RUN with counters nonzero and rd_req pending -> counting=0, rd_valid=0, all reads return 0 afterwards.
